// File: rtl/glitch_sequencer_pkg.sv
// Shared types and default sizing for the glitch sequencer.
package glitch_pkg;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_REPEAT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/glitch_sequencer_up_counter.sv
// Saturating up counter with synchronous clear; clear wins over enable.
module up_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic at_max_s;

    // Saturation detect so long phases never wrap back to zero
    always_comb begin
        at_max_s = (count == {WIDTH{1'b1}});
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {WIDTH{1'b0}};
        end else if (clr) begin
            count <= {WIDTH{1'b0}};
        end else if (en && !at_max_s) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/glitch_sequencer.sv
// Trigger-armed glitch pulse sequencer: delay, then a train of pulses separated by gaps.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int REPEAT_W = DEFAULT_REPEAT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    cfg_delay,
    input  logic [WIDTH-1:0]    cfg_width,
    input  logic [WIDTH-1:0]    cfg_gap,
    input  logic [REPEAT_W-1:0] cfg_repeat,
    input  logic                arm,
    input  logic                abort,
    input  logic                trigger,
    output logic                glitch_out,
    output logic                armed,
    output logic                busy,
    output logic                done,
    output logic [REPEAT_W-1:0] pulse_cnt
);

    state_t              state_r;
    state_t              state_nx_s;
    logic [WIDTH-1:0]    delay_r;
    logic [WIDTH-1:0]    width_r;
    logic [WIDTH-1:0]    gap_r;
    logic [REPEAT_W-1:0] repeat_r;
    logic                trig_hist_r;
    logic                trig_edge_s;
    logic [WIDTH-1:0]    phase_s;
    logic [WIDTH:0]      phase_p1_s;
    logic [WIDTH-1:0]    width_eff_s;
    logic [WIDTH-1:0]    gap_eff_s;
    logic [REPEAT_W-1:0] repeat_eff_s;
    logic [REPEAT_W-1:0] cnt_inc_s;
    logic                clr_s;

    function automatic logic [WIDTH-1:0] at_least_one(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : v;
    endfunction

    up_counter #(
        .WIDTH (WIDTH)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (clr_s),
        .count (phase_s)
    );

    // Effective configuration and next-state selection; abort overrides everything
    always_comb begin
        width_eff_s  = at_least_one(width_r);
        gap_eff_s    = at_least_one(gap_r);
        repeat_eff_s = (repeat_r == {REPEAT_W{1'b0}}) ? {{(REPEAT_W-1){1'b0}}, 1'b1} : repeat_r;
        // One extra bit so a maximal phase+1 compares without wrapping
        phase_p1_s   = {1'b0, phase_s} + {{WIDTH{1'b0}}, 1'b1};
        cnt_inc_s    = pulse_cnt + {{(REPEAT_W-1){1'b0}}, 1'b1};
        trig_edge_s  = trigger && !trig_hist_r;
        state_nx_s   = state_r;
        if (abort) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) state_nx_s = ST_ARMED;
                    else     state_nx_s = ST_IDLE;
                end
                ST_ARMED: begin
                    if (!trig_edge_s)                       state_nx_s = ST_ARMED;
                    else if (delay_r == {WIDTH{1'b0}})      state_nx_s = ST_PULSE;
                    else                                    state_nx_s = ST_DELAY;
                end
                ST_DELAY: begin
                    if (phase_p1_s == {1'b0, delay_r}) state_nx_s = ST_PULSE;
                    else                               state_nx_s = ST_DELAY;
                end
                ST_PULSE: begin
                    if (phase_p1_s != {1'b0, width_eff_s}) state_nx_s = ST_PULSE;
                    else if (cnt_inc_s == repeat_eff_s)    state_nx_s = ST_DONE;
                    else                                   state_nx_s = ST_GAP;
                end
                ST_GAP: begin
                    if (phase_p1_s == {1'b0, gap_eff_s}) state_nx_s = ST_PULSE;
                    else                                 state_nx_s = ST_GAP;
                end
                ST_DONE: begin
                    state_nx_s = ST_IDLE;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
        clr_s = (state_nx_s != state_r);
    end

    // FSM state, shadow configuration, pulse count and registered output decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            delay_r     <= {WIDTH{1'b0}};
            width_r     <= {WIDTH{1'b0}};
            gap_r       <= {WIDTH{1'b0}};
            repeat_r    <= {REPEAT_W{1'b0}};
            trig_hist_r <= 1'b0;
            pulse_cnt   <= {REPEAT_W{1'b0}};
            glitch_out  <= 1'b0;
            armed       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            trig_hist_r <= trigger;
            glitch_out  <= (state_nx_s == ST_PULSE);
            armed       <= (state_nx_s == ST_ARMED);
            busy        <= (state_nx_s == ST_DELAY) || (state_nx_s == ST_PULSE) ||
                           (state_nx_s == ST_GAP);
            done        <= (state_nx_s == ST_DONE);
            if ((state_r == ST_IDLE) && (state_nx_s == ST_ARMED)) begin
                delay_r   <= cfg_delay;
                width_r   <= cfg_width;
                gap_r     <= cfg_gap;
                repeat_r  <= cfg_repeat;
                pulse_cnt <= {REPEAT_W{1'b0}};
            end else if ((state_r == ST_PULSE) &&
                         ((state_nx_s == ST_GAP) || (state_nx_s == ST_DONE))) begin
                pulse_cnt <= cnt_inc_s;
            end else begin
                pulse_cnt <= pulse_cnt;
            end
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed and randomized checks of glitch_sequencer against a waveform-level reference model.
module tb_glitch_sequencer;

    localparam int W  = 4;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  cfg_delay = '0;
    logic [W-1:0]  cfg_width = '0;
    logic [W-1:0]  cfg_gap = '0;
    logic [RW-1:0] cfg_repeat = '0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trigger = 1'b0;
    logic          glitch_out;
    logic          armed;
    logic          busy;
    logic          done;
    logic [RW-1:0] pulse_cnt;

    int checks = 0;
    int errors = 0;

    glitch_sequencer #(
        .WIDTH    (W),
        .REPEAT_W (RW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_gap    (cfg_gap),
        .cfg_repeat (cfg_repeat),
        .arm        (arm),
        .abort      (abort),
        .trigger    (trigger),
        .glitch_out (glitch_out),
        .armed      (armed),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One arm/trigger run; the expected waveform is derived from pulse arithmetic
    task automatic shot(input int d, input int w, input int g, input int r,
                        input bit pre_high, input int abort_req);
        int we, ge, re, per, endn, expcnt, m, abort_at;
        logic eg;
        we   = (w == 0) ? 1 : w;
        ge   = (g == 0) ? 1 : g;
        re   = (r == 0) ? 1 : r;
        per  = we + ge;
        endn = d + re * we + (re - 1) * ge;
        abort_at = (abort_req == -2) ? int'($urandom_range(0, endn)) : abort_req;

        cfg_delay  = W'(d);
        cfg_width  = W'(w);
        cfg_gap    = W'(g);
        cfg_repeat = RW'(r);
        arm = 1'b1;
        trigger = pre_high;
        step();
        arm = 1'b0;
        cfg_delay  = W'($urandom);
        cfg_width  = W'($urandom);
        cfg_gap    = W'($urandom);
        cfg_repeat = RW'($urandom);
        chk("armed_after_arm", 32'(armed), 32'd1);
        chk("pulse_cnt_cleared", 32'(pulse_cnt), 32'd0);

        if (pre_high) begin
            repeat (3) begin
                step();
                chk("armed_hold_high", 32'(armed), 32'd1);
                chk("no_fire_while_high", 32'(busy | glitch_out), 32'd0);
            end
            trigger = 1'b0;
            step();
            chk("armed_after_drop", 32'(armed), 32'd1);
        end
        repeat ($urandom_range(0, 2)) begin
            step();
            chk("armed_wait", 32'(armed), 32'd1);
        end

        trigger = 1'b1;
        step();
        for (int n = 0; n <= endn + 1; n++) begin
            if (abort_at >= 0 && n == abort_at + 1) begin
                chk("abort_glitch", 32'(glitch_out), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                chk("abort_armed", 32'(armed), 32'd0);
                break;
            end
            eg = 1'b0;
            if (n >= d) begin
                m = n - d;
                if ((m / per) < re && (m % per) < we) eg = 1'b1;
            end
            chk("glitch", 32'(glitch_out), 32'(eg));
            chk("done", 32'(done), 32'(n == endn));
            chk("busy", 32'(busy), 32'(n < endn));
            chk("armed_run", 32'(armed), 32'd0);
            abort = (n == abort_at);
            trigger = 1'($urandom);
            step();
        end
        abort = 1'b0;

        expcnt = re;
        if (abort_at >= 0) begin
            expcnt = 0;
            for (int i = 0; i < re; i++) begin
                if (d + i * per + we - 1 < abort_at) expcnt++;
            end
        end
        chk("pulse_cnt", 32'(pulse_cnt), 32'(expcnt));
    endtask

    initial begin
        repeat (2) step();
        chk("rst_glitch", 32'(glitch_out), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
        rst_n = 1'b1;
        step();

        shot(3, 2, 1, 1, 1'b0, -1);
        shot(0, 1, 2, 3, 1'b0, -1);

        shot(0, 0, 0, 0, 1'b0, -1);
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        repeat (3) begin
            step();
            chk("idle_trigger_glitch", 32'(glitch_out), 32'd0);
            chk("idle_trigger_busy", 32'(busy), 32'd0);
        end

        shot(2, 2, 1, 2, 1'b1, -1);
        shot(1, 3, 1, 4, 1'b0, 6);
        shot(15, 15, 15, 7, 1'b0, -1);

        for (int k = 0; k < 24; k++) begin
            shot(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? -2 : -1);
        end

        // Asynchronous reset in the middle of a pulse
        cfg_delay = 4'd0; cfg_width = 4'd8; cfg_gap = 4'd1; cfg_repeat = 3'd1;
        trigger = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trigger = 1'b1;
        step();
        step();
        chk("pre_reset_glitch", 32'(glitch_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_glitch", 32'(glitch_out), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        chk("async_reset_pulse_cnt", 32'(pulse_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        trigger = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk("arm_after_reset", 32'(armed), 32'd1);
        abort = 1'b1;
        arm = 1'b1;
        step();
        abort = 1'b0;
        arm = 1'b0;
        chk("abort_beats_arm", 32'(armed), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
